// File: rtl/fp_mul_pkg.sv
// Shared definitions for the FP multiplier mantissa/exponent stage.
//   state_e    : control FSM states of fp_mul_core
//   exp_bias   : exponent bias for a given exponent field width
//   prod_width : width of the full unnormalised mantissa product
package fp_mul_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  function automatic int unsigned exp_bias(input int unsigned e_width);
    return (1 << (e_width - 1)) - 1;
  endfunction

  // Two (M_WIDTH+1)-bit mantissas give a 2*M_WIDTH+2 bit product.
  function automatic int unsigned prod_width(input int unsigned m_width);
    return 2 * m_width + 2;
  endfunction

endpackage

// File: rtl/exp_bias_add.sv
// Combinational exponent adder for the FP multiplier.
// Each biased exponent is promoted to its effective value (0 counts as 1,
// matching denormal scaling). The two are added and one bias is removed.
// The result is a two's-complement value two bits wider than the field, and
// it is not saturated.
//   a_exp, b_exp : biased exponents (E_WIDTH)
//   exp_sum      : effA + effB - BIAS (E_WIDTH+2, two's complement)
module exp_bias_add
  import fp_mul_pkg::*;
#(
  parameter int unsigned E_WIDTH = 8
) (
  input  logic [E_WIDTH-1:0] a_exp,
  input  logic [E_WIDTH-1:0] b_exp,
  output logic [E_WIDTH+1:0] exp_sum
);

  localparam int unsigned SumW = E_WIDTH + 2;
  localparam logic [SumW-1:0] Bias = SumW'(exp_bias(E_WIDTH));

  logic [SumW-1:0] eff_a;
  logic [SumW-1:0] eff_b;

  always_comb begin
    eff_a   = (a_exp == '0) ? SumW'(1) : SumW'(a_exp);
    eff_b   = (b_exp == '0) ? SumW'(1) : SumW'(b_exp);
    exp_sum = eff_a + eff_b - Bias;
  end

endmodule

// File: rtl/fp_mul_core.sv
// Iterative mantissa multiply and exponent add stage of the FP multiplier.
// The stage accepts one operand set in IDLE. It then runs M_WIDTH+1 radix-2
// shift-and-add iterations in BUSY, and it holds the result in DONE until the
// downstream stage takes it.
//   clk, reset            : rising-edge clock, async active-low reset
//   in_valid / in_ready   : operand handshake (ready only in IDLE)
//   in_sign               : result sign, passed through registered
//   a_with_hid/b_with_hid : mantissas with hidden bit (M_WIDTH+1)
//   a_exp / b_exp         : biased exponents (E_WIDTH)
//   out_valid / out_ready : result handshake (valid only in DONE)
//   out_sign, out_prod    : registered sign, unnormalised product
//   out_exp               : biased exponent sum, E_WIDTH+2 two's complement
module fp_mul_core
  import fp_mul_pkg::*;
#(
  parameter int unsigned E_WIDTH = 8,
  parameter int unsigned M_WIDTH = 23
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [M_WIDTH:0]       a_with_hid,
  input  logic [M_WIDTH:0]       b_with_hid,
  input  logic [E_WIDTH-1:0]     a_exp,
  input  logic [E_WIDTH-1:0]     b_exp,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sign,
  output logic [2*M_WIDTH+1:0]   out_prod,
  output logic [E_WIDTH+1:0]     out_exp
);

  localparam int unsigned MantW = M_WIDTH + 1;
  localparam int unsigned ProdW = prod_width(M_WIDTH);
  localparam int unsigned CntW  = $clog2(M_WIDTH + 1);

  state_e             state_q, state_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [ProdW-1:0]   acc_q, acc_d;
  logic [MantW-1:0]   mplier_q, mplier_d;
  logic [MantW-1:0]   mcand_q, mcand_d;
  logic [E_WIDTH+1:0] exp_q, exp_d;
  logic               sign_q, sign_d;

  logic [E_WIDTH+1:0] exp_sum;
  logic [MantW:0]     partial;  // upper accumulator half plus carry-out

  exp_bias_add #(
    .E_WIDTH (E_WIDTH)
  ) u_exp_bias_add (
    .a_exp   (a_exp),
    .b_exp   (b_exp),
    .exp_sum (exp_sum)
  );

  always_comb begin
    partial = {1'b0, acc_q[ProdW-1 -: MantW]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    exp_d    = exp_q;
    sign_d   = sign_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          mcand_d  = a_with_hid;
          mplier_d = b_with_hid;
          exp_d    = exp_sum;
          sign_d   = in_sign;
          acc_d    = '0;
          count_d  = '0;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        // Shift {carry, sum, lower half} right by one; the LSB drops off.
        acc_d    = {partial, acc_q[MantW-1:1]};
        mplier_d = mplier_q >> 1;
        if (count_q == CntW'(M_WIDTH)) begin
          state_d = StDone;
        end else begin
          count_d = count_q + CntW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      count_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_prod  = acc_q;
  assign out_exp   = exp_q;
  assign out_sign  = sign_q;

endmodule

// File: tb/tb_fp_mul_core.sv
// Self-checking bench for fp_mul_core (default parameters).
// Expected products and exponents come from plain integer arithmetic.
module tb_fp_mul_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [23:0] a_with_hid = '0;
  logic [23:0] b_with_hid = '0;
  logic [7:0]  a_exp = '0;
  logic [7:0]  b_exp = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_sign;
  logic [47:0] out_prod;
  logic [9:0]  out_exp;

  int checks = 0;
  int failures = 0;

  fp_mul_core #(
    .E_WIDTH (8),
    .M_WIDTH (23)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .a_with_hid (a_with_hid),
    .b_with_hid (b_with_hid),
    .a_exp      (a_exp),
    .b_exp      (b_exp),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sign   (out_sign),
    .out_prod   (out_prod),
    .out_exp    (out_exp)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [47:0] model_prod(input logic [23:0] a, input logic [23:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    return p[47:0];
  endfunction

  function automatic logic [9:0] model_exp(input logic [7:0] ea, input logic [7:0] eb);
    int e;
    logic [9:0] r;
    e = ((ea == 0) ? 1 : int'(ea)) + ((eb == 0) ? 1 : int'(eb)) - 127;
    r = e[9:0];
    return r;
  endfunction

  task automatic scramble_inputs();
    a_with_hid = 24'($urandom);
    b_with_hid = 24'($urandom);
    a_exp      = 8'($urandom);
    b_exp      = 8'($urandom);
    in_sign    = 1'($urandom);
  endtask

  // One full transaction: accept, wait for result, optional backpressure, handshake.
  task automatic do_op(input string tag, input logic [23:0] a, input logic [23:0] b,
                       input logic [7:0] ea, input logic [7:0] eb, input logic s,
                       input int hold, input bit busy_poke);
    logic [47:0] wp;
    logic [9:0]  we;
    int          n;
    int          lat;
    wp = model_prod(a, b);
    we = model_exp(ea, eb);
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq({tag, "_ready_pre"}, 64'(in_ready), 64'd1);
    a_with_hid = a; b_with_hid = b; a_exp = ea; b_exp = eb; in_sign = s;
    in_valid = 1'b1;
    @(posedge clk); #1;  // accept edge
    in_valid = 1'b0;
    scramble_inputs();
    lat = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk); #1;
      scramble_inputs();
      in_valid = busy_poke && (cyc == 5);
      if (out_valid) begin
        lat = cyc;
        break;
      end
    end
    in_valid = 1'b0;
    check_eq({tag, "_latency"}, 64'(lat), 64'd24);
    check_eq({tag, "_ready_done"}, 64'(in_ready), 64'd0);
    check_eq({tag, "_prod"}, 64'(out_prod), 64'(wp));
    check_eq({tag, "_exp"}, 64'(out_exp), 64'(we));
    check_eq({tag, "_sign"}, 64'(out_sign), 64'(s));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check_eq({tag, "_hold"}, {4'b0, out_valid, in_ready, out_sign, out_exp, out_prod},
               {4'b0, 1'b1, 1'b0, s, we, wp});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;  // handshake edge
    out_ready = 1'b0;
    check_eq({tag, "_valid_post"}, 64'(out_valid), 64'd0);
    check_eq({tag, "_ready_post"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", 64'(in_ready), 64'd1);
    check_eq("rst_outs", {13'b0, out_valid, out_sign, out_exp, out_prod}, 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("rel_ready", 64'(in_ready), 64'd1);
    check_eq("rel_valid", 64'(out_valid), 64'd0);

    do_op("one",   24'h800000, 24'h800000, 8'd127, 8'd127, 1'b0, 0, 1'b0);
    check_eq("one_known", 64'(model_prod(24'h800000, 24'h800000)), 64'h400000000000);
    do_op("onep5", 24'hC00000, 24'hC00000, 8'd127, 8'd127, 1'b1, 0, 1'b0);
    do_op("two_half", 24'h800000, 24'h800000, 8'd128, 8'd126, 1'b0, 0, 1'b0);
    do_op("max",   24'hFFFFFF, 24'hFFFFFF, 8'd254, 8'd254, 1'b1, 0, 1'b0);
    do_op("denorm", 24'h000001, 24'h000003, 8'd0, 8'd0, 1'b0, 0, 1'b0);
    do_op("bp",    24'hABCDEF, 24'h9A5A5A, 8'd100, 8'd30, 1'b1, 5, 1'b1);
    // The handshake above leaves in_ready high, so this accept is one edge later.
    do_op("bp_next", 24'hC00000, 24'h800000, 8'd1, 8'd255, 1'b0, 0, 1'b0);

    // Reset in the middle of BUSY.
    a_with_hid = 24'hFFFFFF; b_with_hid = 24'hFFFFFF; a_exp = 8'd200; b_exp = 8'd200;
    in_sign = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_eq("midrst_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_outs", {14'b0, out_sign, out_exp, out_prod}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("midrst_ready", 64'(in_ready), 64'd1);
    check_eq("midrst_valid2", 64'(out_valid), 64'd0);
    do_op("after_rst", 24'h800000, 24'h800000, 8'd127, 8'd127, 1'b0, 0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      logic [23:0] ra, rb;
      ra = ($urandom_range(0, 3) == 0) ? 24'($urandom) : {1'b1, 23'($urandom)};
      rb = ($urandom_range(0, 3) == 0) ? 24'($urandom) : {1'b1, 23'($urandom)};
      do_op("rand", ra, rb, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_mul_core.md
# fp_mul_core

Iterative mantissa-multiply and exponent-add stage of the FP multiplier. It sits directly downstream of the operand pre-processing stage. It accepts one operand set per transaction:
- the result sign,
- both mantissas with the hidden bit attached,
- both raw biased exponents.

It produces the full-width unnormalised mantissa product and the unbiased-then-rebiased exponent sum. The normalise/round stage consumes these through a valid/ready handshake.

## Interface
Parameters:
- E_WIDTH, 8, exponent field width
- M_WIDTH, 23, stored fraction width (mantissa with hidden bit is M_WIDTH+1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  operand set present
- in_ready  out  1  stage can accept operands
- in_sign  in  1  result sign from pre-processing
- a_with_hid  in  M_WIDTH+1  mantissa A, hidden bit in MSB
- b_with_hid  in  M_WIDTH+1  mantissa B, hidden bit in MSB
- a_exp  in  E_WIDTH  biased exponent A
- b_exp  in  E_WIDTH  biased exponent B
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- out_sign  out  1  registered in_sign
- out_prod  out  2*M_WIDTH+2  unnormalised product
- out_exp  out  E_WIDTH+2  two's-complement biased exponent sum

## Operation
- BIAS = 2^(E_WIDTH-1) - 1 (127 default).
- Effective exponent is max(exp, 1), so exp 0 (denormal/zero) counts as 1.
- out_exp = effA + effB - BIAS. It is computed at accept, at E_WIDTH+2 bits, with no saturation. Negative values and values ≥ 2^E_WIDTH-1 pass through for the downstream under/overflow logic.
- Product: radix-2 shift-and-add.
  - Accumulator is 2*M_WIDTH+2 bits. The multiplier register is loaded with b_with_hid; the multiplicand is held as a_with_hid.
  - Each BUSY cycle: if the multiplier LSB is 1, add the multiplicand to the accumulator upper half (with carry-out). Then shift {carry, accumulator} right by 1 and shift the multiplier right by 1.
  - The result is exact; there is no early termination, and zero operands take full latency.
- FSM states:
  - IDLE: in_ready=1. On in_valid → load operands, clear accumulator, clear count → BUSY.
  - BUSY: iterate; count increments 0..M_WIDTH. At the edge where count==M_WIDTH, do the final iteration → DONE.
  - DONE: out_valid=1. On out_ready → IDLE.
- in_ready is high only in IDLE; there is no accept while BUSY or DONE.
- Outputs out_prod, out_exp and out_sign stay stable while out_valid=1 and out_ready=0.
- Inputs are sampled only at the accept edge; later input changes are ignored.
- out_ready is ignored outside DONE.

## Timing
- Reset values: in_ready=1 after reset releases (combinational from IDLE). out_valid=0, out_prod=0, out_exp=0, out_sign=0. State is IDLE, count is 0.
- Asserting reset at any point, mid-BUSY included, aborts the transaction immediately with no residual output.
- Accept at edge t0 → out_valid rises after edge t0+M_WIDTH+1 (24 for default).
- Output handshake at edge t1 → IDLE after t1; earliest next accept is edge t1+1.
- Throughput: one result per M_WIDTH+3 cycles when out_ready is held high.

## Structure
- Shared package fp_mul_pkg holds:
  - the state enum IDLE/BUSY/DONE;
  - a BIAS function/constant of E_WIDTH;
  - a product-width constant.
- One sub-module, exp_bias_add: purely combinational effective-exponent selection and the sum minus BIAS. It is instantiated once; its result is registered at accept.
- The FSM, counter (clog2(M_WIDTH+1) bits) and shift-add datapath live in fp_mul_core.

## Test plan
- 1.0×1.0: a/b_with_hid=0x800000, exps 127/127 → out_prod=0x400000000000, out_exp=127, out_valid exactly 24 cycles after accept.
- 1.5×1.5: 0xC00000 each, exps 127/127 → out_prod=0x900000000000, out_exp=127. Also 2.0×0.5: exps 128/126, mantissas 0x800000 → out_exp=127.
- Max: 0xFFFFFF each, exps 254/254 → out_prod=0xFFFFFE000001, out_exp=381 (0x17D).
- Denormal: a_with_hid=0x000001, b_with_hid=0x000003, exps 0/0 → out_prod=0x3, out_exp=-125 (0x383 in 10 bits).
- Backpressure: hold out_ready=0 for 5 cycles in DONE → outputs unchanged and in_ready=0 throughout. The in_valid pulse during BUSY is ignored. Release → next accept occurs one cycle after the handshake.
- Reset mid-op: assert reset 10 cycles after accept → out_valid=0 immediately, in_ready=1 after release. A subsequent 1.0×1.0 returns correct results.
